// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter that shares the register file's single write port among
// NUM_REQ writeback producers, with a registered write stage and a contention counter.

module wb_arb_lane #(
  parameter int REG_W = 5
) (
  input  logic             valid_i,
  input  logic [REG_W-1:0] rd_i,
  output logic             elig_o,
  output logic             x0_o
);
  assign elig_o = valid_i && (rd_i != '0);
  assign x0_o   = valid_i && (rd_i == '0);
endmodule

module wb_port_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int CNT_W   = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*REG_W-1:0]  req_rd,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      flush,
  output logic                      rf_we,
  output logic [REG_W-1:0]          rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic [CNT_W-1:0]          contention_cnt
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]             elig, x0, gnt_oh;
  logic [NUM_REQ-1:0][REG_W-1:0]  rd_a;
  logic [NUM_REQ-1:0][DATA_W-1:0] data_a;
  logic                           gnt_vld, take, multi;
  logic [PTR_W-1:0]               gnt_idx, ptr_q, ptr_d;
  logic                           rf_we_q, rf_we_d;
  logic [REG_W-1:0]               rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]              rf_wdata_q, rf_wdata_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign rd_a[i]   = req_rd[i*REG_W +: REG_W];
    assign data_a[i] = req_data[i*DATA_W +: DATA_W];
    wb_arb_lane #(.REG_W(REG_W)) u_lane (
      .valid_i (req_valid[i]),
      .rd_i    (rd_a[i]),
      .elig_o  (elig[i]),
      .x0_o    (x0[i])
    );
  end

  // First eligible index at or after ptr, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_vld && elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = PTR_W'(idx);
      end
    end
    if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
  end

  // x0 writes are acked and dropped without touching the write port.
  assign req_ready = (reset || flush) ? '0 : (gnt_oh | x0);

  assign take  = gnt_vld && !flush;
  assign multi = $countones(elig) >= 2;

  always_comb begin
    rf_we_d    = take;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    if (take) begin
      rf_waddr_d = rd_a[gnt_idx];
      rf_wdata_d = data_a[gnt_idx];
      ptr_d      = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
    if (!flush && multi && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rf_we          = rf_we_q;
  assign rf_waddr       = rf_waddr_q;
  assign rf_wdata       = rf_wdata_q;
  assign contention_cnt = cnt_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, single write, round-robin order,
// x0 drop, flush, async reset mid-write and counter saturation (CNT_W=4).

module tb_wb_port_arbiter;
  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int CNT_W   = 4;

  logic                      clock = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*REG_W-1:0]  req_rd;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      flush;
  logic                      rf_we;
  logic [REG_W-1:0]          rf_waddr;
  logic [DATA_W-1:0]         rf_wdata;
  logic [CNT_W-1:0]          contention_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] rf_mem [32];

  wb_port_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_rd         (req_rd),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .flush          (flush),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .contention_cnt (contention_cnt)
  );

  always #5 clock = ~clock;

  // Register file model: commits on the falling edge.
  always @(negedge clock) if (rf_we) rf_mem[rf_waddr] <= rf_wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [REG_W-1:0] rd,
                         input logic [DATA_W-1:0] d);
    req_valid[i]               = v;
    req_rd[i*REG_W +: REG_W]   = rd;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    req_valid = '0; req_rd = '0; req_data = '0;
    // Reset state; ready held low even with live requests.
    set_req(0, 1'b1, 5'd4, 32'h1);
    set_req(1, 1'b1, 5'd0, 32'h2);
    #2;
    chk("reset_ready", 64'(req_ready), 64'h0);
    chk("reset_we", 64'(rf_we), 64'h0);
    chk("reset_waddr", 64'(rf_waddr), 64'h0);
    chk("reset_wdata", 64'(rf_wdata), 64'h0);
    chk("reset_cnt", 64'(contention_cnt), 64'h0);
    req_valid = '0;
    @(negedge clock); reset = 1'b0;

    // Single request.
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    #1 chk("single_ready", 64'(req_ready), 64'b001);
    step();
    req_valid = '0;
    chk("single_we", 64'(rf_we), 64'h1);
    chk("single_waddr", 64'(rf_waddr), 64'd5);
    chk("single_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    @(negedge clock); #1;
    chk("single_rf5", 64'(rf_mem[5]), 64'hDEADBEEF);
    step();
    chk("idle_we", 64'(rf_we), 64'h0);
    chk("idle_waddr_hold", 64'(rf_waddr), 64'd5);

    // Three-way round robin from ptr=0.
    reset = 1'b1; #1;
    @(negedge clock); reset = 1'b0;
    set_req(0, 1'b1, 5'd1, 32'h11);
    set_req(1, 1'b1, 5'd2, 32'h22);
    set_req(2, 1'b1, 5'd3, 32'h33);
    #1 chk("rr1_ready", 64'(req_ready), 64'b001);
    step();
    chk("rr1_waddr", 64'(rf_waddr), 64'd1);
    chk("rr1_cnt", 64'(contention_cnt), 64'd1);
    req_valid[0] = 1'b0;
    #1 chk("rr2_ready", 64'(req_ready), 64'b010);
    step();
    chk("rr2_waddr", 64'(rf_waddr), 64'd2);
    chk("rr2_cnt", 64'(contention_cnt), 64'd2);
    req_valid[1] = 1'b0;
    #1 chk("rr3_ready", 64'(req_ready), 64'b100);
    step();
    chk("rr3_waddr", 64'(rf_waddr), 64'd3);
    chk("rr3_cnt", 64'(contention_cnt), 64'd2);
    req_valid = 3'b011;
    #1 chk("rr4_ready", 64'(req_ready), 64'b001);
    step();
    chk("rr4_waddr", 64'(rf_waddr), 64'd1);
    chk("rr4_cnt", 64'(contention_cnt), 64'd3);
    // Continuous three-way from ptr=1: 1,2,0.
    req_valid = 3'b111;
    #1 chk("rr5_ready", 64'(req_ready), 64'b010);
    step();
    chk("rr5_waddr", 64'(rf_waddr), 64'd2);
    #1 chk("rr6_ready", 64'(req_ready), 64'b100);
    step();
    chk("rr6_waddr", 64'(rf_waddr), 64'd3);
    #1 chk("rr7_ready", 64'(req_ready), 64'b001);
    step();
    chk("rr7_waddr", 64'(rf_waddr), 64'd1);
    chk("rr7_cnt", 64'(contention_cnt), 64'd6);
    req_valid = '0;

    // x0 drop alongside a real write; ptr=1.
    set_req(0, 1'b1, 5'd7, 32'h77);
    set_req(1, 1'b1, 5'd0, 32'hBAD);
    #1 chk("x0_ready", 64'(req_ready), 64'b011);
    step();
    chk("x0_we", 64'(rf_we), 64'h1);
    chk("x0_waddr", 64'(rf_waddr), 64'd7);
    chk("x0_wdata", 64'(rf_wdata), 64'h77);
    chk("x0_cnt", 64'(contention_cnt), 64'd6);
    // ptr must now be 1: req1 beats req0.
    set_req(1, 1'b1, 5'd4, 32'h44);
    #1 chk("x0_ptr_probe", 64'(req_ready), 64'b011 & 64'b010);
    req_valid = '0;

    // Flush with two eligible requesters and an x0 request.
    set_req(0, 1'b1, 5'd3, 32'h30);
    set_req(1, 1'b1, 5'd0, 32'h0);
    set_req(2, 1'b1, 5'd9, 32'h99);
    flush = 1'b1;
    #1 chk("flush_ready", 64'(req_ready), 64'h0);
    step();
    chk("flush_we", 64'(rf_we), 64'h0);
    chk("flush_cnt", 64'(contention_cnt), 64'd6);
    flush = 1'b0;
    req_valid = 3'b100;
    #1 chk("postflush_ready", 64'(req_ready), 64'b100);
    step();
    chk("postflush_waddr", 64'(rf_waddr), 64'd9);
    chk("postflush_wdata", 64'(rf_wdata), 64'h99);
    req_valid = '0;

    // Move ptr to 2, then async reset while a write is pending.
    set_req(1, 1'b1, 5'd10, 32'hA);
    step();
    chk("pre_rst_we", 64'(rf_we), 64'h1);
    set_req(1, 1'b1, 5'd12, 32'hC);
    set_req(2, 1'b1, 5'd13, 32'hD);
    #2 reset = 1'b1;
    #1;
    chk("rst_we", 64'(rf_we), 64'h0);
    chk("rst_waddr", 64'(rf_waddr), 64'h0);
    chk("rst_wdata", 64'(rf_wdata), 64'h0);
    chk("rst_cnt", 64'(contention_cnt), 64'h0);
    chk("rst_ready", 64'(req_ready), 64'h0);
    @(negedge clock); reset = 1'b0;
    #1 chk("post_rst_ready", 64'(req_ready), 64'b010);
    step();
    chk("post_rst_waddr", 64'(rf_waddr), 64'd12);
    chk("post_rst_cnt", 64'(contention_cnt), 64'd1);

    // Saturation: 20 contention cycles starting from 1.
    set_req(0, 1'b1, 5'd1, 32'h1);
    set_req(1, 1'b1, 5'd2, 32'h2);
    set_req(2, 1'b1, 5'd3, 32'h3);
    repeat (13) step();
    chk("sat_14", 64'(contention_cnt), 64'd14);
    step();
    chk("sat_15", 64'(contention_cnt), 64'd15);
    repeat (6) step();
    chk("sat_hold", 64'(contention_cnt), 64'd15);
    req_valid = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
